acc_result_drain: RTL and testbench
===================================

Name: acc_result_drain

Overview:
- Read side of the accelerator output FIFO.
- Pops 128-bit computed words, each with its end-of-frame flag, and serialises them into OUT_W-bit beats on a valid/ready stream toward the host/NVMe datapath.
- Marks the final beat of a frame, pulses frame completion, and reports busy state to the command controller.

Parameters:
- OUT_W, 32, output beat width; legal values 32, 64, 128. BEATS = 128/OUT_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  permits new FIFO reads; an in-flight word always completes
- fifo_empty  in  1  output FIFO empty flag
- fifo_rd_en  out  1  FIFO pop strobe, registered, one cycle per word
- fifo_dout  in  128  FIFO read data, valid the cycle after fifo_rd_en (standard, non-FWFT)
- fifo_last  in  1  end-of-frame flag stored alongside fifo_dout, same timing
- m_data  out  OUT_W  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from the sink
- m_last  out  1  high on the final beat of the final word of a frame
- frame_done  out  1  one-cycle pulse after the m_last beat is accepted
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, frame_done=0, busy=0, state=IDLE, beat counter=0, hold register=0.
- States (one-hot): IDLE, READ, LOAD, SEND.
- IDLE: if enable && !fifo_empty, go to READ and drive fifo_rd_en=1 for that cycle only. Otherwise stay.
- READ: go to LOAD; fifo_rd_en=0.
- LOAD: capture fifo_dout into the hold register and fifo_last into last_word. Set beat=0, m_valid=1, m_data=hold[OUT_W-1:0]. Go to SEND.
- SEND: a handshake is m_valid && m_ready.
  - On a handshake with beat<BEATS-1: beat+1, and m_data=hold[(beat+1)*OUT_W +: OUT_W]. Least-significant slice goes first.
  - While m_ready=0: m_data, m_valid and m_last hold stable.
  - m_last = last_word && (beat==BEATS-1).
- Final-beat handshake:
  - m_valid falls the next cycle; m_last clears with it.
  - If last_word=1, frame_done pulses in the next cycle.
  - If enable && !fifo_empty, go directly to READ with fifo_rd_en=1. Otherwise go to IDLE.
- Throughput: BEATS beats per BEATS+2 cycles when m_ready is held high. First m_valid appears 3 cycles after IDLE sees a non-empty FIFO.
- fifo_rd_en is never asserted while fifo_empty=1 or while a word is held.
- enable deasserted mid-word: the current word drains fully, then the block stays in IDLE.
- fifo_empty toggling during SEND: no effect until the final beat.
- Reset mid-frame: the held word is discarded and all outputs return to reset values next cycle. No m_last or frame_done is issued.
- OUT_W=128: BEATS=1; every word is one beat.
- A frame is any run of words terminated by fifo_last=1. There is no length limit.

Optional Feature:
- Macro: ACC_DRAIN_STATS_EN.
- Enabled:
  - Adds output frame_words (out, 32), reset 0.
  - Internal counter increments on each fifo_rd_en and wraps at 2^32.
  - On the frame_done cycle, frame_words loads the final count (including the last word) and the internal counter clears to 0.
- Disabled: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package acc_pkg holds:
  - state encodings ST_IDLE, ST_READ, ST_LOAD, ST_SEND (one-hot, 4 bits)
  - ACC_WORD_W=128
  - the legal OUT_W set
- One natural sub-module: acc_beat_serializer, containing the hold register, beat counter and slice mux. It takes load/advance inputs and produces data/last_beat outputs.
- The FSM and the FIFO handshake stay in the top module.

Test Plan:
- Single word 128'h00112233_44556677_8899AABB_CCDDEEFF with last=1, OUT_W=32, m_ready=1:
  - beats CCDDEEFF, 8899AABB, 44556677, 00112233
  - m_last only on the 4th beat; frame_done one cycle later; fifo_rd_en pulsed exactly once.
- 3-word frame, last set on word 3 only:
  - 12 beats; m_last on beat 12 only; no idle gap longer than 2 cycles between words; frame_words=3 when ACC_DRAIN_STATS_EN is defined.
- Backpressure: m_ready low for 5 cycles on beat 2:
  - m_data and m_valid stable throughout; no extra fifo_rd_en; the sequence resumes unchanged.
- enable dropped during beat 1 of word 1 in a 2-word FIFO:
  - word 1 completes all 4 beats; no read of word 2 until enable returns; then word 2 drains.
- Reset asserted on beat 3 of a last word:
  - next cycle all outputs are 0 and state is IDLE; no m_last or frame_done; the following frame drains normally.
- OUT_W=128 with 2 words, last on word 2:
  - 2 beats; m_last on beat 2; fifo_empty=1 thereafter keeps fifo_rd_en=0.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accelerator result drain.
//   ACC_WORD_W   width of one computed word popped from the output FIFO
//   acc_state_e  one-hot drain FSM encoding (ST_IDLE, ST_READ, ST_LOAD, ST_SEND)
//   out_w_legal  legal output beat widths: 32, 64, 128
package acc_pkg;

  localparam int unsigned ACC_WORD_W = 128;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_READ = 4'b0010,
    ST_LOAD = 4'b0100,
    ST_SEND = 4'b1000
  } acc_state_e;

  // Beat width must divide the word into a power-of-two number of slices.
  function automatic bit out_w_legal(input int unsigned w);
    return (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/acc_beat_serializer.sv
// acc_beat_serializer: holds one 128-bit word and steps through it in
// OUT_W-bit slices, least-significant slice first.
//   clk, reset    clock, synchronous active-low reset
//   load          capture din, present slice 0
//   advance       present the next slice (never issued on the final slice)
//   din           word from the FIFO
//   data          current slice (registered)
//   last_beat     current slice is the final one of the word (registered)
//   next_last_c   the slice that advance would present is the final one
module acc_beat_serializer
  import acc_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ACC_WORD_W-1:0] din,
  output logic [OUT_W-1:0]      data,
  output logic                  last_beat,
  output logic                  next_last_c
);

  localparam int unsigned BEATS  = ACC_WORD_W / OUT_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned NSLOT  = 1 << BEAT_W;

  logic [ACC_WORD_W-1:0] hold;
  logic [BEAT_W-1:0]     beat;
  logic [BEAT_W-1:0]     beat_nxt;
  logic [OUT_W-1:0]      slices [NSLOT];

  // Slice table padded to a power of two so the beat index is always in range.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slice
    assign slices[i] = hold[(i % BEATS) * OUT_W +: OUT_W];
  end

  assign beat_nxt    = beat + BEAT_W'(1);
  assign next_last_c = (beat_nxt == BEAT_W'(BEATS - 1));

  // Hold register, beat counter and registered slice output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold      <= '0;
      beat      <= '0;
      data      <= '0;
      last_beat <= 1'b0;
    end else if (load) begin
      hold      <= din;
      beat      <= '0;
      data      <= din[OUT_W-1:0];
      last_beat <= (BEATS == 1);
    end else if (advance) begin
      beat      <= beat_nxt;
      data      <= slices[beat_nxt];
      last_beat <= next_last_c;
    end
  end

endmodule

// File: rtl/acc_result_drain.sv
// acc_result_drain: read side of the accelerator output FIFO. Pops 128-bit
// words (standard, non-FWFT timing) and serialises them into OUT_W-bit beats
// on a valid/ready stream, flagging the final beat of each frame.
//   clk, reset             clock, synchronous active-low reset
//   enable                 permits new FIFO reads; an in-flight word completes
//   fifo_empty             FIFO empty flag
//   fifo_rd_en             FIFO pop strobe, one cycle per word
//   fifo_dout, fifo_last   word and end-of-frame flag, valid after fifo_rd_en
//   m_data/m_valid/m_ready stream toward the host datapath
//   m_last                 final beat of the final word of a frame
//   frame_done             one-cycle pulse after the m_last beat is accepted
//   busy                   FSM is not idle
//   frame_words            words in the last completed frame
//                          (only when ACC_DRAIN_STATS_EN is defined)
module acc_result_drain
  import acc_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [ACC_WORD_W-1:0] fifo_dout,
  input  logic                  fifo_last,
  output logic [OUT_W-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  busy
`ifdef ACC_DRAIN_STATS_EN
  ,
  output logic [31:0]           frame_words
`endif
);

  localparam int unsigned BEATS       = ACC_WORD_W / OUT_W;
  localparam bit          SINGLE_BEAT = (BEATS == 1);

  if (!out_w_legal(OUT_W)) begin : g_bad_out_w
    $error("acc_result_drain: OUT_W must be 32, 64 or 128");
  end

  acc_state_e state_q, state_d;
  logic       last_word, last_word_d;
  logic       rd_en_d, m_valid_d, m_last_d, frame_done_d;
  logic       load, advance;
  logic       can_read_c, handshake_c;
  logic       ser_last_beat, ser_next_last_c;

  assign can_read_c  = enable && !fifo_empty;
  assign handshake_c = m_valid && m_ready;

  acc_beat_serializer #(.OUT_W(OUT_W)) u_ser (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .advance     (advance),
    .din         (fifo_dout),
    .data        (m_data),
    .last_beat   (ser_last_beat),
    .next_last_c (ser_next_last_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fifo_rd_en <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      last_word  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_rd_en <= rd_en_d;
      m_valid    <= m_valid_d;
      m_last     <= m_last_d;
      frame_done <= frame_done_d;
      busy       <= (state_d != ST_IDLE);
      last_word  <= last_word_d;
    end
  end

  // Next state and output decode.
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    m_valid_d    = m_valid;
    m_last_d     = m_last;
    frame_done_d = 1'b0;
    last_word_d  = last_word;
    load         = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (can_read_c) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load        = 1'b1;
        last_word_d = fifo_last;
        m_valid_d   = 1'b1;
        m_last_d    = fifo_last && SINGLE_BEAT;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (handshake_c) begin
          if (!ser_last_beat) begin
            advance  = 1'b1;
            m_last_d = last_word && ser_next_last_c;
          end else begin
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
            frame_done_d = last_word;
            // Chain straight into the next read so a frame streams back to back.
            if (can_read_c) begin
              state_d = ST_READ;
              rd_en_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef ACC_DRAIN_STATS_EN
  // Word count per frame; a pop coinciding with frame_done belongs to the next frame.
  logic [31:0] word_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt    <= '0;
      frame_words <= '0;
    end else if (frame_done) begin
      frame_words <= word_cnt;
      word_cnt    <= {31'b0, fifo_rd_en};
    end else if (fifo_rd_en) begin
      word_cnt    <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_result_drain.sv
module tb_acc_result_drain;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: OUT_W = 32
  logic         enable_a = 1'b0, m_ready_a = 1'b0;
  logic         fifo_empty_a = 1'b1, fifo_last_a = 1'b0;
  logic [127:0] fifo_dout_a = '0;
  logic         fifo_rd_en_a, m_valid_a, m_last_a, frame_done_a, busy_a;
  logic [31:0]  m_data_a;
  // DUT B: OUT_W = 128
  logic         enable_b = 1'b0, m_ready_b = 1'b0;
  logic         fifo_empty_b = 1'b1, fifo_last_b = 1'b0;
  logic [127:0] fifo_dout_b = '0;
  logic         fifo_rd_en_b, m_valid_b, m_last_b, frame_done_b, busy_b;
  logic [127:0] m_data_b;
`ifdef ACC_DRAIN_STATS_EN
  logic [31:0]  frame_words_a, frame_words_b;
`endif

  acc_result_drain #(.OUT_W(32)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .fifo_empty(fifo_empty_a),
    .fifo_rd_en(fifo_rd_en_a), .fifo_dout(fifo_dout_a), .fifo_last(fifo_last_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a),
    .frame_done(frame_done_a), .busy(busy_a)
`ifdef ACC_DRAIN_STATS_EN
    , .frame_words(frame_words_a)
`endif
  );

  acc_result_drain #(.OUT_W(128)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .fifo_empty(fifo_empty_b),
    .fifo_rd_en(fifo_rd_en_b), .fifo_dout(fifo_dout_b), .fifo_last(fifo_last_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b),
    .frame_done(frame_done_b), .busy(busy_b)
`ifdef ACC_DRAIN_STATS_EN
    , .frame_words(frame_words_b)
`endif
  );

  // Reference model state: FIFO contents and expected beat streams {last, data}.
  logic [128:0] q_a[$], q_b[$];
  logic [32:0]  exp_a[$], obs_a[$];
  logic [128:0] exp_b[$], obs_b[$];
  int acc_cyc_a[$];
  int frames_a = 0, frames_b = 0;
  int rd_cnt_a = 0, rd_cnt_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;
  int rd_viol_a = 0, rd_viol_b = 0, fd_viol_a = 0, fd_viol_b = 0, stab_viol_a = 0;
  int cyc_a = 0;
  bit pend_a = 0, pend_b = 0;

  // Non-FWFT FIFO models: data and empty change the cycle after a pop.
  always @(negedge clk) begin
    #2;
    if (pend_a && q_a.size() > 0) {fifo_last_a, fifo_dout_a} = q_a.pop_front();
    if (pend_b && q_b.size() > 0) {fifo_last_b, fifo_dout_b} = q_b.pop_front();
    pend_a = fifo_rd_en_a;
    pend_b = fifo_rd_en_b;
    if (fifo_rd_en_a) begin
      rd_cnt_a++;
      if (q_a.size() == 0 || m_valid_a) rd_viol_a++;
    end
    if (fifo_rd_en_b) begin
      rd_cnt_b++;
      if (q_b.size() == 0 || m_valid_b) rd_viol_b++;
    end
    fifo_empty_a = (q_a.size() == 0);
    fifo_empty_b = (q_b.size() == 0);
  end

  // Stream monitors: accepted beats, frame_done timing, stall stability.
  bit stall_a = 0, fd_pend_a = 0, fd_pend_b = 0, pl_a = 0;
  logic [31:0] pd_a = '0;
  always @(negedge clk) begin
    #1;
    cyc_a++;
    if (!reset) begin
      stall_a = 0; fd_pend_a = 0; fd_pend_b = 0;
    end else begin
      if (frame_done_a !== fd_pend_a) fd_viol_a++;
      if (frame_done_a) fd_cnt_a++;
      if (stall_a && (m_valid_a !== 1'b1 || m_data_a !== pd_a || m_last_a !== pl_a)) stab_viol_a++;
      if (m_valid_a && m_ready_a) begin
        obs_a.push_back({m_last_a, m_data_a});
        acc_cyc_a.push_back(cyc_a);
      end
      stall_a = m_valid_a && !m_ready_a;
      pd_a = m_data_a; pl_a = m_last_a;
      fd_pend_a = m_valid_a && m_ready_a && m_last_a;
      if (frame_done_b !== fd_pend_b) fd_viol_b++;
      if (frame_done_b) fd_cnt_b++;
      if (m_valid_b && m_ready_b) obs_b.push_back({m_last_b, m_data_b});
      fd_pend_b = m_valid_b && m_ready_b && m_last_b;
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // A word becomes four beats, low slice first; only the top slice of a last word is marked.
  task automatic push_a(input logic [127:0] d, input logic l);
    q_a.push_back({l, d});
    for (int i = 0; i < 4; i++) exp_a.push_back({l && (i == 3), d[i*32 +: 32]});
    if (l) frames_a++;
  endtask

  task automatic push_b(input logic [127:0] d, input logic l);
    q_b.push_back({l, d});
    exp_b.push_back({l, d});
    if (l) frames_b++;
  endtask

  task automatic clear_a();
    obs_a.delete(); exp_a.delete(); acc_cyc_a.delete();
    rd_cnt_a = 0; fd_cnt_a = 0; frames_a = 0;
  endtask

  function automatic int diff_a();
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      if (obs_a[i] !== exp_a[i]) return i;
    return -1;
  endfunction

  task automatic wait_idle_a(input int budget, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(busy_a == 1'b0 && fifo_empty_a && obs_a.size() >= exp_a.size()) && n < budget);
    repeat (3) @(negedge clk);
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s timeout: obs=%0d beats, need %0d", tag, obs_a.size(), exp_a.size());
    end
  endtask

  task automatic check_stream_a(input string tag);
    int d;
    d = diff_a();
    checks++;
    if (obs_a.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL %s beat count: got %0d, need %0d", tag, obs_a.size(), exp_a.size());
    end
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL %s beat %0d: got %h, need %h", tag, d, obs_a[d], exp_a[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_rd_en_a, m_valid_a, m_data_a, m_last_a, frame_done_a, busy_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got rd=%b v=%b d=%h l=%b fd=%b busy=%b, need all 0",
               fifo_rd_en_a, m_valid_a, m_data_a, m_last_a, frame_done_a, busy_a);
    end
    checks++;
    if ({fifo_rd_en_b, m_valid_b, m_data_b, m_last_b, frame_done_b, busy_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got rd=%b v=%b d=%h l=%b fd=%b busy=%b, need all 0",
               fifo_rd_en_b, m_valid_b, m_data_b, m_last_b, frame_done_b, busy_b);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n = 0;
    clear_a();
    enable_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    push_a(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    while (!m_valid_a && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL single latency: got %0d cycles, need 3", n);
    end
    wait_idle_a(50, "single");
    check_stream_a("single");
    checks++;
    if (obs_a.size() != 4 || obs_a[0] !== 33'h0_CCDDEEFF || obs_a[3] !== 33'h1_00112233) begin
      errors++; $display("FAIL single beats: got %0d beats, need CCDDEEFF..00112233 with last on 4th", obs_a.size());
    end
    checks++;
    if (rd_cnt_a !== 1 || fd_cnt_a !== 1) begin
      errors++; $display("FAIL single counts: got rd=%0d fd=%0d, need 1/1", rd_cnt_a, fd_cnt_a);
    end
    checks++;
    if (acc_cyc_a.size() != 4 || acc_cyc_a[3] - acc_cyc_a[0] !== 3) begin
      errors++; $display("FAIL single span: got %0d accepts, need 4 consecutive", acc_cyc_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    clear_a();
    enable_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    push_a(rand128(), 1'b0); push_a(rand128(), 1'b0); push_a(rand128(), 1'b1);
    wait_idle_a(100, "b2b");
    check_stream_a("b2b");
    for (int i = 1; i < acc_cyc_a.size(); i++)
      if (acc_cyc_a[i] - acc_cyc_a[i-1] > gap) gap = acc_cyc_a[i] - acc_cyc_a[i-1];
    checks++;
    if (acc_cyc_a.size() != 12 || acc_cyc_a[11] - acc_cyc_a[0] !== 15 || gap !== 3) begin
      errors++; $display("FAIL b2b throughput: got %0d beats, max step %0d, need 12 beats over 15 cycles, step 3", acc_cyc_a.size(), gap);
    end
    checks++;
    if (rd_cnt_a !== 3 || fd_cnt_a !== 1) begin
      errors++; $display("FAIL b2b counts: got rd=%0d fd=%0d, need 3/1", rd_cnt_a, fd_cnt_a);
    end
`ifdef ACC_DRAIN_STATS_EN
    checks++;
    if (frame_words_a !== 32'd3) begin
      errors++; $display("FAIL b2b frame_words: got %0d, need 3", frame_words_a);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [127:0] w;
    int n = 0;
    w = 128'h44444444_33333333_22222222_11111111;
    clear_a();
    enable_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    push_a(w, 1'b1);
    while (!(m_valid_a && m_data_a == 32'h22222222) && n < 20) begin @(negedge clk); n++; end
    m_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({m_valid_a, m_data_a, m_last_a, fifo_rd_en_a} !== {1'b1, 32'h22222222, 1'b0, 1'b0}) begin
        errors++; $display("FAIL stall cycle %0d: got v=%b d=%h l=%b rd=%b, need v=1 d=22222222 l=0 rd=0",
                           i, m_valid_a, m_data_a, m_last_a, fifo_rd_en_a);
      end
    end
    m_ready_a = 1'b1;
    wait_idle_a(50, "stall");
    check_stream_a("stall");
    checks++;
    if (rd_cnt_a !== 1) begin
      errors++; $display("FAIL stall reads: got %0d, need 1", rd_cnt_a);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    clear_a();
    enable_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    push_a(rand128(), 1'b0); push_a(rand128(), 1'b1);
    while (!m_valid_a && n < 10) begin @(negedge clk); n++; end
    enable_a = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (obs_a.size() !== 4 || diff_a() !== -1) begin
      errors++; $display("FAIL en_drop word1: got %0d beats (first diff %0d), need 4 matching", obs_a.size(), diff_a());
    end
    checks++;
    if (rd_cnt_a !== 1 || busy_a !== 1'b0 || fifo_empty_a !== 1'b0) begin
      errors++; $display("FAIL en_drop hold: got rd=%0d busy=%b empty=%b, need 1/0/0", rd_cnt_a, busy_a, fifo_empty_a);
    end
    enable_a = 1'b1;
    wait_idle_a(50, "en_drop");
    check_stream_a("en_drop");
    checks++;
    if (rd_cnt_a !== 2 || fd_cnt_a !== 1) begin
      errors++; $display("FAIL en_drop counts: got rd=%0d fd=%0d, need 2/1", rd_cnt_a, fd_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_a();
    enable_a = 1'b1; m_ready_a = 1'b1;
    @(negedge clk);
    push_a(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
    while (!(m_valid_a && m_data_a == 32'hCCCCCCCC) && n < 20) begin @(negedge clk); n++; end
    reset = 1'b0; m_ready_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_rd_en_a, m_valid_a, m_data_a, m_last_a, frame_done_a, busy_a} !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got rd=%b v=%b d=%h l=%b fd=%b busy=%b, need all 0",
                         fifo_rd_en_a, m_valid_a, m_data_a, m_last_a, frame_done_a, busy_a);
    end
    reset = 1'b1; m_ready_a = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_a.size() !== 2 || obs_a[0][32] !== 1'b0 || obs_a[1][32] !== 1'b0 || fd_cnt_a !== 0) begin
      errors++; $display("FAIL reset_mid aborted: got %0d beats, fd=%0d, need 2 non-last beats and fd=0", obs_a.size(), fd_cnt_a);
    end
    clear_a();
    push_a(rand128(), 1'b0); push_a(rand128(), 1'b1);
    wait_idle_a(60, "post_reset");
    check_stream_a("post_reset");
    checks++;
    if (fd_cnt_a !== 1 || rd_cnt_a !== 2) begin
      errors++; $display("FAIL post_reset counts: got fd=%0d rd=%0d, need 1/2", fd_cnt_a, rd_cnt_a);
    end
  endtask

  task automatic test_random();
    int n = 0;
    clear_a();
    @(negedge clk);
    for (int i = 0; i < 16; i++) push_a(rand128(), $urandom_range(0, 3) == 0);
    while (obs_a.size() < exp_a.size() + 64 && n < 4000) begin
      @(negedge clk); n++;
      m_ready_a = ($urandom_range(0, 99) < 65);
      enable_a  = ($urandom_range(0, 99) < 85);
      if (n == 40) begin
        for (int i = 0; i < 15; i++) push_a(rand128(), $urandom_range(0, 3) == 0);
        push_a(rand128(), 1'b1);
      end
      if (n > 40 && obs_a.size() >= exp_a.size()) break;
    end
    m_ready_a = 1'b1; enable_a = 1'b1;
    wait_idle_a(200, "random");
    check_stream_a("random");
    checks++;
    if (rd_cnt_a !== 32 || fd_cnt_a !== frames_a) begin
      errors++; $display("FAIL random counts: got rd=%0d fd=%0d, need 32/%0d", rd_cnt_a, fd_cnt_a, frames_a);
    end
  endtask

  task automatic test_out128();
    logic [127:0] w1, w2;
    int n = 0;
    w1 = rand128(); w2 = rand128();
    enable_b = 1'b1; m_ready_b = 1'b1;
    @(negedge clk);
    push_b(w1, 1'b0); push_b(w2, 1'b1);
    while (!(busy_b == 1'b0 && fifo_empty_b && obs_b.size() >= 2) && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++;
    if (obs_b.size() !== 2 || obs_b[0] !== exp_b[0] || obs_b[1] !== exp_b[1]) begin
      errors++; $display("FAIL out128 beats: got %0d beats, need 2 with last on the 2nd only", obs_b.size());
    end
    checks++;
    if (rd_cnt_b !== 2 || fd_cnt_b !== frames_b || fifo_rd_en_b !== 1'b0) begin
      errors++; $display("FAIL out128 counts: got rd=%0d fd=%0d rd_en=%b, need 2/%0d/0", rd_cnt_b, fd_cnt_b, fifo_rd_en_b, frames_b);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (stab_viol_a !== 0) begin
      errors++; $display("FAIL stall stability: got %0d violations, need 0", stab_viol_a);
    end
    checks++;
    if (fd_viol_a !== 0 || fd_viol_b !== 0) begin
      errors++; $display("FAIL frame_done timing: got %0d/%0d violations, need 0", fd_viol_a, fd_viol_b);
    end
    checks++;
    if (rd_viol_a !== 0 || rd_viol_b !== 0) begin
      errors++; $display("FAIL illegal read: got %0d/%0d violations, need 0", rd_viol_a, rd_viol_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_random();
    test_out128();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
